// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: debug bridge req/ack access channel
interface regfile_access_ctrl_if;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    modport master (output dbg_req, dbg_we, dbg_addr, dbg_wdata, input dbg_ack, dbg_rdata);
    modport slave (input dbg_req, dbg_we, dbg_addr, dbg_wdata, output dbg_ack, dbg_rdata);
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: init sweep, core passthrough and debug arbitration for a 2R1W register file
module regfile_access_ctrl #(
    parameter logic [31:0] INIT_VALUE = 32'd0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4:0]                  core_rs1,
    input  logic [4:0]                  core_rs2,
    input  logic [4:0]                  core_rd,
    input  logic                        core_we,
    input  logic [31:0]                 core_wd,
    output logic                        core_stall,
    regfile_access_ctrl_if.slave        dbg,
    output logic [4:0]                  rf_rs1,
    output logic [4:0]                  rf_rs2,
    output logic [4:0]                  rf_rd,
    output logic                        rf_we,
    output logic [31:0]                 rf_wd,
    input  logic [31:0]                 rf_rd1,
    output logic                        init_done
);
    typedef enum logic [2:0] {INIT, RUN, GRANT, CAPT, ACK} state_t;
    state_t     state;
    logic [4:0] idx;
    logic       core_own;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            idx           <= 5'd1;
            dbg.dbg_ack   <= 1'b0;
            dbg.dbg_rdata <= 32'd0;
            init_done     <= 1'b0;
        end else begin
            dbg.dbg_ack <= 1'b0;
            case (state)
                INIT: begin
                    idx <= idx + 5'd1;
                    if (idx == 5'd31) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: if (dbg.dbg_req) state <= GRANT;
                GRANT: begin
                    state       <= dbg.dbg_we ? ACK : CAPT;
                    dbg.dbg_ack <= dbg.dbg_we;
                end
                CAPT: begin
                    dbg.dbg_rdata <= rf_rd1;
                    dbg.dbg_ack   <= 1'b1;
                    state         <= ACK;
                end
                default: state <= RUN;
            endcase
        end
    end
    // Read port A is only stolen during a debug read grant; CAPT hands it back to the core
    always_comb begin
        core_own   = state == RUN || state == ACK;
        core_stall = rst || !core_own;
        rf_rs1     = (state == GRANT && !dbg.dbg_we) ? dbg.dbg_addr : core_rs1;
        rf_rs2     = core_rs2;
        rf_rd      = state == INIT ? idx : state == GRANT ? dbg.dbg_addr : core_rd;
        rf_wd      = state == INIT ? INIT_VALUE : state == GRANT ? dbg.dbg_wdata : core_wd;
        rf_we      = !rst && (state == INIT || (state == GRANT ? dbg.dbg_we && dbg.dbg_addr != 5'd0
                                                               : core_own && core_we));
    end
endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Sequencer and arbiter placed in front of the 32x32 synchronous-read register file (2 read ports, 1 write port, x0 hardwired to zero, 1-cycle read latency).
- After reset, it sweeps x1..x31 to a known value, because the register file itself has no reset.
- It then passes core traffic through and interleaves single-register debug reads and writes (UART/debug bridge) using a req/ack handshake, stalling the core while the debug access owns the ports.

Parameters:
- INIT_VALUE, 32'd0: value written to x1..x31 during the init sweep.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- core_rs1  in  5  core read address A
- core_rs2  in  5  core read address B
- core_rd  in  5  core write address
- core_we  in  1  core write enable
- core_wd  in  32  core write data
- core_stall  out  1  core must hold all core_* inputs while high
- dbg_req  in  1  debug request; held until ack
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req is high
- dbg_addr  in  5  debug register index; stable while dbg_req is high
- dbg_wdata  in  32  debug write data; stable while dbg_req is high
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  read result; valid from the dbg_ack cycle and held until the next read completes
- rf_rs1  out  5  to register file rs1
- rf_rs2  out  5  to register file rs2
- rf_rd  out  5  to register file rd
- rf_we  out  1  to register file we
- rf_wd  out  32  to register file wd
- rf_rd1  in  32  from register file rd1 (used for debug read capture)
- init_done  out  1  high once the sweep has completed

Behaviour:
- States:
  - INIT: sweep.
  - RUN: core passthrough.
  - GRANT: debug owns the ports.
  - CAPT: capture debug read data.
  - ACK: debug completion.
- Reset:
  - rst high in any cycle forces INIT at the next edge, with idx=1, dbg_ack=0, dbg_rdata=0, init_done=0.
  - In the rst cycle itself: rf_we=0, core_stall=1.
  - A transaction in flight is abandoned; no ack is issued for it.
- INIT:
  - rf_we=1, rf_rd=idx, rf_wd=INIT_VALUE, core_stall=1.
  - idx increments 1..31, taking 31 cycles.
  - After idx=31 → RUN, and init_done goes high in the first RUN cycle.
  - dbg_req during INIT stays pending and is not acked.
- RUN (no grant):
  - core_stall=0.
  - rf_rs1/rs2/rd/we/wd = core_rs1/rs2/rd/we/wd.
- Read-port rule: rf_rs1/rf_rs2 carry the core addresses in every state except a GRANT cycle for a debug read.
  - So the core's data is valid in rf_rd1/rd2 in its first non-stalled cycle.
- Arbitration in RUN:
  - dbg_req=1 → GRANT on the next edge.
  - The core retains the ports in that RUN cycle, and core_we in it is honoured.
  - Debug wins over the core for the duration of GRANT (plus CAPT for reads).
  - ACK always has core_stall=0, which guarantees at least one free core cycle between debug transactions.
- GRANT:
  - core_stall=1; core_we is ignored (the core holds it, and it is re-issued once the stall drops).
  - Write: rf_we=(dbg_addr!=0), rf_rd=dbg_addr, rf_wd=dbg_wdata; next state ACK.
  - Read: rf_we=0, rf_rs1=dbg_addr; next state CAPT.
- CAPT:
  - core_stall=1, rf_we=0, rf_rs1=core_rs1.
  - dbg_rdata <= rf_rd1 at the edge.
  - Next state ACK.
- ACK:
  - dbg_ack=1, core_stall=0, core passthrough as in RUN.
  - Next state RUN.
  - The requester drops dbg_req in the cycle after dbg_ack; a req still high two cycles after ack starts a new transaction.
- Latency from the GRANT cycle: write ack at +1, read ack at +2. Core stall is 1 cycle for a write, 2 cycles for a read.
- x0 handling:
  - A debug write to x0 is acked but never drives rf_we.
  - A debug read of x0 returns 0, because the register file returns zero for x0.
- dbg_we, dbg_addr and dbg_wdata are sampled in GRANT only.

Test Plan:
1. Reset release → for 31 consecutive cycles rf_we=1 with rf_rd=1..31 and rf_wd=0; init_done=1 and core_stall=0 on the 32nd cycle.
2. In RUN, debug write x5=0xDEADBEEF while the core holds a write x6=0x11 → RUN cycle: rf_rd=6, rf_wd=0x11. GRANT cycle: rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF, stall=1. ACK cycle: dbg_ack=1, and the core's write to x6 is re-issued because it is held.
3. Debug read x5 after test 2 → GRANT: rf_rs1=5. CAPT: stall=1. ACK: dbg_ack=1 with dbg_rdata=0xDEADBEEF; the core's rd1 is valid for core_rs1 in the ACK cycle.
4. Debug write x0=0xFFFFFFFF, then debug read x0 → the write produces no rf_we pulse and still acks; the read returns dbg_rdata=0.
5. dbg_req asserted 3 cycles after reset release → the sweep completes all 31 writes uninterrupted; GRANT occurs in the cycle after the first RUN cycle.
6. rst asserted during CAPT → no dbg_ack; dbg_rdata=0; the next cycle is INIT with rf_rd=1 and core_stall=1.
